// File: rtl/sprite_tile_addr_gen.sv
// sprite_tile_addr_gen: BRAM address generator for a runtime-writable tile map
// overlaid by NUM_SPR animated sprites (index 0 has the highest priority).
// Pipeline: S0 issues the map read and evaluates sprite hits. S1 composes the
// address into pixel_addr. A sideband shift chain then delays show/tile/sprite
// flags so that they line up with the BRAM read data.
module sprite_tile_addr_gen #(
  parameter int NUM_SPR    = 2,
  parameter int TILE_SHIFT = 5,
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int TID_W      = 4,
  parameter int ADDR_W     = 17,
  parameter int TILE_BASE  = 0,
  parameter int BRAM_LAT   = 2,
  parameter int INSET_X    = 3,
  parameter int INSET_TOP  = 5,
  localparam int IDX_W     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                h_cnt,
  input  logic [9:0]                v_cnt,
  input  logic                      vsync,
  input  logic [10*NUM_SPR-1:0]     spr_x,
  input  logic [10*NUM_SPR-1:0]     spr_y,
  input  logic [NUM_SPR-1:0]        spr_en,
  input  logic [NUM_SPR-1:0]        spr_flip,
  input  logic [3*NUM_SPR-1:0]      spr_frame,
  input  logic [ADDR_W*NUM_SPR-1:0] spr_base,
  input  logic [8*NUM_SPR-1:0]      spr_sheet_w,
  input  logic [(1<<TID_W)-1:0]     tile_hide,
  input  logic                      map_we,
  input  logic [8:0]                map_waddr,
  input  logic [TID_W-1:0]          map_wdata,
  output logic [ADDR_W-1:0]         pixel_addr,
  output logic                      out_show_pixel,
  output logic [TID_W-1:0]          out_tile_id,
  output logic                      out_is_char_sync,
  output logic [IDX_W-1:0]          out_spr_idx
);

  localparam int MAP_N   = MAP_COLS * MAP_ROWS;
  localparam int MAP_AW  = (MAP_N > 1) ? $clog2(MAP_N) : 1;
  localparam int TILE_PX = 1 << TILE_SHIFT;
  localparam int SIDE_W  = 2 + TID_W + IDX_W;

  // Shadow copies of the sprite inputs, stable for a whole frame
  logic                      vs_d;
  logic [10*NUM_SPR-1:0]     sh_x;
  logic [10*NUM_SPR-1:0]     sh_y;
  logic [NUM_SPR-1:0]        sh_en;
  logic [NUM_SPR-1:0]        sh_flip;
  logic [3*NUM_SPR-1:0]      sh_frame;
  logic [ADDR_W*NUM_SPR-1:0] sh_base;
  logic [8*NUM_SPR-1:0]      sh_sheet;

  // Map RAM and its synchronous read port
  logic [TID_W-1:0] map_ram [MAP_N];
  logic [TID_W-1:0] map_rdata;
  logic [15:0]      map_raddr;

  // S0 -> S1 registers
  logic [9:0]         s1_h;
  logic [9:0]         s1_v;
  logic               s1_in;
  logic [NUM_SPR-1:0] s1_hit;
  logic [NUM_SPR-1:0] hit_s0;
  logic [10:0]        h11;
  logic [10:0]        v11;

  // S1 combinational results
  logic [TID_W-1:0]      tid;
  logic                  tile_vis;
  logic [NUM_SPR-1:0]    hit_v;
  logic                  any_hit;
  logic [IDX_W-1:0]      win;
  logic [9:0]            sel_x;
  logic [9:0]            sel_y;
  logic                  sel_flip;
  logic [2:0]            sel_frame;
  logic [ADDR_W-1:0]     sel_base;
  logic [7:0]            sel_sheet;
  logic [TILE_SHIFT-1:0] rel_x;
  logic [TILE_SHIFT-1:0] lx_rel;
  logic [9:0]            ly;
  logic [ADDR_W-1:0]     spr_addr;
  logic [ADDR_W-1:0]     tile_addr;
  logic [ADDR_W-1:0]     addr_s1;
  logic [SIDE_W-1:0]     side_s1;
  logic [SIDE_W-1:0]     side_pipe [BRAM_LAT+1];

  // Latch all sprite inputs once on each vsync rising edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_d     <= 1'b0;
      sh_x     <= '0;
      sh_y     <= '0;
      sh_en    <= '0;
      sh_flip  <= '0;
      sh_frame <= '0;
      sh_base  <= '0;
      sh_sheet <= '0;
    end else begin
      vs_d <= vsync;
      if (vsync && !vs_d) begin
        sh_x     <= spr_x;
        sh_y     <= spr_y;
        sh_en    <= spr_en;
        sh_flip  <= spr_flip;
        sh_frame <= spr_frame;
        sh_base  <= spr_base;
        sh_sheet <= spr_sheet_w;
      end
    end
  end

  assign map_raddr = 16'((v_cnt >> TILE_SHIFT) * MAP_COLS + (h_cnt >> TILE_SHIFT));

  // Map RAM: read-first write port plus a registered read; off-map reads give 0
  always_ff @(posedge clk) begin
    if (map_we && (int'(map_waddr) < MAP_N))
      map_ram[map_waddr[MAP_AW-1:0]] <= map_wdata;
    if (int'(map_raddr) < MAP_N)
      map_rdata <= map_ram[map_raddr[MAP_AW-1:0]];
    else
      map_rdata <= '0;
  end

  assign h11 = {1'b0, h_cnt};
  assign v11 = {1'b0, v_cnt};

  // Sprite hitbox test in 11 bits so that boxes near the right/bottom edge cannot wrap
  always_comb begin
    hit_s0 = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      hit_s0[i] = sh_en[i]
        && (h11 >= ({1'b0, sh_x[10*i +: 10]} + 11'(INSET_X)))
        && (h11 <  ({1'b0, sh_x[10*i +: 10]} + 11'(TILE_PX - INSET_X)))
        && (v11 >= ({1'b0, sh_y[10*i +: 10]} + 11'(INSET_TOP)))
        && (v11 <  ({1'b0, sh_y[10*i +: 10]} + 11'(TILE_PX)));
    end
  end

  // S0 -> S1 pipeline register
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_h   <= '0;
      s1_v   <= '0;
      s1_in  <= 1'b0;
      s1_hit <= '0;
    end else begin
      s1_h   <= h_cnt;
      s1_v   <= v_cnt;
      s1_in  <= (h_cnt < 10'd640) && (v_cnt < 10'd480);
      s1_hit <= hit_s0;
    end
  end

  assign tid      = s1_in ? map_rdata : '0;
  assign tile_vis = (tid != '0) && !tile_hide[tid];
  assign hit_v    = s1_hit & {NUM_SPR{s1_in}};
  assign any_hit  = |hit_v;

  // Priority mux: scanning downwards leaves the lowest hitting sprite selected
  always_comb begin
    win       = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_flip  = 1'b0;
    sel_frame = '0;
    sel_base  = '0;
    sel_sheet = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        win       = IDX_W'(i);
        sel_x     = sh_x[10*i +: 10];
        sel_y     = sh_y[10*i +: 10];
        sel_flip  = sh_flip[i];
        sel_frame = sh_frame[3*i +: 3];
        sel_base  = sh_base[ADDR_W*i +: ADDR_W];
        sel_sheet = sh_sheet[8*i +: 8];
      end
    end
  end

  // Mirroring (2^TILE_SHIFT-1-rel_x) is a bitwise inversion at TILE_SHIFT width
  assign rel_x     = TILE_SHIFT'(s1_h - sel_x);
  assign lx_rel    = sel_flip ? ~rel_x : rel_x;
  assign ly        = s1_v - sel_y;
  assign spr_addr  = sel_base
                   + ADDR_W'(ly) * ADDR_W'(sel_sheet)
                   + (ADDR_W'(sel_frame) << TILE_SHIFT)
                   + ADDR_W'(lx_rel);
  assign tile_addr = ADDR_W'(TILE_BASE)
                   + (ADDR_W'(tid - TID_W'(1)) << (2 * TILE_SHIFT))
                   + (ADDR_W'(s1_v[TILE_SHIFT-1:0]) << TILE_SHIFT)
                   + ADDR_W'(s1_h[TILE_SHIFT-1:0]);
  assign addr_s1   = any_hit ? spr_addr : (tile_vis ? tile_addr : '0);
  assign side_s1   = {any_hit || tile_vis, tid, any_hit, win};

  // Address register and the sideband chain that delays the flags by BRAM_LAT
  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_addr <= '0;
      for (int k = 0; k <= BRAM_LAT; k++) side_pipe[k] <= '0;
    end else begin
      pixel_addr   <= addr_s1;
      side_pipe[0] <= side_s1;
      for (int k = 1; k <= BRAM_LAT; k++) side_pipe[k] <= side_pipe[k-1];
    end
  end

  assign {out_show_pixel, out_tile_id, out_is_char_sync, out_spr_idx} = side_pipe[BRAM_LAT];

endmodule

// File: tb/tb_sprite_tile_addr_gen.sv
// Testbench for sprite_tile_addr_gen: pixel streams (directed and $urandom)
// checked against a behavioural model of the tile map and sprite overlay.
module tb_sprite_tile_addr_gen;
  localparam int NUM_SPR = 2;
  localparam int ADDR_W  = 17;
  localparam int MAP_N   = 300;
  localparam int MAXPIX  = 64;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [9:0]                h_cnt = '0;
  logic [9:0]                v_cnt = '0;
  logic                      vsync = 1'b0;
  logic [10*NUM_SPR-1:0]     spr_x = '0;
  logic [10*NUM_SPR-1:0]     spr_y = '0;
  logic [NUM_SPR-1:0]        spr_en = '0;
  logic [NUM_SPR-1:0]        spr_flip = '0;
  logic [3*NUM_SPR-1:0]      spr_frame = '0;
  logic [ADDR_W*NUM_SPR-1:0] spr_base = '0;
  logic [8*NUM_SPR-1:0]      spr_sheet_w = '0;
  logic [15:0]               tile_hide = '0;
  logic                      map_we = 1'b0;
  logic [8:0]                map_waddr = '0;
  logic [3:0]                map_wdata = '0;
  logic [ADDR_W-1:0]         pixel_addr;
  logic                      out_show_pixel;
  logic [3:0]                out_tile_id;
  logic                      out_is_char_sync;
  logic [0:0]                out_spr_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: map contents and the sprite values latched at vsync
  int m_map [MAP_N];
  int ms_x [NUM_SPR], ms_y [NUM_SPR], ms_en [NUM_SPR], ms_flip [NUM_SPR];
  int ms_frame [NUM_SPR], ms_base [NUM_SPR], ms_sheet [NUM_SPR];

  // Stream description, model expectations and captured DUT outputs
  int                ph [MAXPIX], pv [MAXPIX];
  bit                pw_en [MAXPIX];
  int                pw_addr [MAXPIX], pw_data [MAXPIX];
  logic [ADDR_W-1:0] e_addr [MAXPIX], a_addr [MAXPIX];
  logic [6:0]        e_side [MAXPIX], a_side [MAXPIX];

  sprite_tile_addr_gen #(
    .NUM_SPR(2), .TILE_SHIFT(5), .MAP_COLS(20), .MAP_ROWS(15), .TID_W(4),
    .ADDR_W(17), .TILE_BASE(0), .BRAM_LAT(2), .INSET_X(3), .INSET_TOP(5)
  ) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .vsync(vsync),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_flip(spr_flip),
    .spr_frame(spr_frame), .spr_base(spr_base), .spr_sheet_w(spr_sheet_w),
    .tile_hide(tile_hide), .map_we(map_we), .map_waddr(map_waddr),
    .map_wdata(map_wdata), .pixel_addr(pixel_addr),
    .out_show_pixel(out_show_pixel), .out_tile_id(out_tile_id),
    .out_is_char_sync(out_is_char_sync), .out_spr_idx(out_spr_idx)
  );

  always #20 clk = ~clk;

  // Expected outputs for one pixel; side = {show, tile_id, is_char, spr_idx}
  function automatic void model_pixel(input int h, input int v,
                                      output logic [ADDR_W-1:0] addr,
                                      output logic [6:0] side);
    int  tid, hit, rel, lx, a;
    bit  on, tvis;
    on   = (h < 640) && (v < 480);
    tid  = on ? m_map[(v / 32) * 20 + h / 32] : 0;
    tvis = (tid != 0) && (tile_hide[tid] == 1'b0);
    hit  = -1;
    if (on)
      for (int i = 0; i < NUM_SPR; i++)
        if (hit < 0 && ms_en[i] != 0 && h >= ms_x[i] + 3 && h < ms_x[i] + 29 &&
            v >= ms_y[i] + 5 && v < ms_y[i] + 32)
          hit = i;
    if (hit >= 0) begin
      rel = h - ms_x[hit];
      lx  = (ms_flip[hit] != 0) ? 31 - rel : rel;
      lx  = lx + ms_frame[hit] * 32;
      a   = (ms_base[hit] + (v - ms_y[hit]) * ms_sheet[hit] + lx) % 131072;
    end else if (tvis) begin
      a = (tid - 1) * 1024 + (v % 32) * 32 + (h % 32);
    end else begin
      a = 0;
    end
    addr = ADDR_W'(a);
    side = {((hit >= 0) || tvis) ? 1'b1 : 1'b0, 4'(tid),
            (hit >= 0) ? 1'b1 : 1'b0, (hit > 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input int en,
                            input int flip, input int frame, input int base,
                            input int sheet);
    spr_x[10*i +: 10]             = 10'(x);
    spr_y[10*i +: 10]             = 10'(y);
    spr_en[i]                     = (en != 0);
    spr_flip[i]                   = (flip != 0);
    spr_frame[3*i +: 3]           = 3'(frame);
    spr_base[ADDR_W*i +: ADDR_W]  = ADDR_W'(base);
    spr_sheet_w[8*i +: 8]         = 8'(sheet);
  endtask

  task automatic model_capture();
    for (int i = 0; i < NUM_SPR; i++) begin
      ms_x[i]     = int'(spr_x[10*i +: 10]);
      ms_y[i]     = int'(spr_y[10*i +: 10]);
      ms_en[i]    = int'(spr_en[i]);
      ms_flip[i]  = int'(spr_flip[i]);
      ms_frame[i] = int'(spr_frame[3*i +: 3]);
      ms_base[i]  = int'(spr_base[ADDR_W*i +: ADDR_W]);
      ms_sheet[i] = int'(spr_sheet_w[8*i +: 8]);
    end
  endtask

  task automatic latch_sprites();
    h_cnt = 10'd800;
    v_cnt = 10'd600;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    model_capture();
    vsync = 1'b0;
    tick();
  endtask

  task automatic write_map(input int a, input int d);
    map_we    = 1'b1;
    map_waddr = 9'(a);
    map_wdata = 4'(d);
    tick();
    map_we = 1'b0;
    if (a < MAP_N) m_map[a] = d;
  endtask

  // One pixel per clock; addr captured 2 edges later, sideband 4 edges later
  task automatic run_pixels(input int n);
    for (int k = 0; k < n + 3; k++) begin
      if (k < n) begin
        h_cnt = 10'(ph[k]);
        v_cnt = 10'(pv[k]);
        model_pixel(ph[k], pv[k], e_addr[k], e_side[k]);
        map_we    = pw_en[k];
        map_waddr = 9'(pw_addr[k]);
        map_wdata = 4'(pw_data[k]);
        if (pw_en[k] && pw_addr[k] < MAP_N) m_map[pw_addr[k]] = pw_data[k];
        pw_en[k] = 1'b0;
      end else begin
        h_cnt  = 10'd800;
        v_cnt  = 10'd600;
        map_we = 1'b0;
      end
      tick();
      if (k >= 1 && k - 1 < n) a_addr[k-1] = pixel_addr;
      if (k >= 3 && k - 3 < n)
        a_side[k-3] = {out_show_pixel, out_tile_id, out_is_char_sync, out_spr_idx};
    end
    map_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] ea;
    logic [6:0]        es;
    // Recovery latency: a tile pixel held across reset release
    tile_hide = '0;
    vsync     = 1'b0;
    h_cnt     = 10'd40;
    v_cnt     = 10'd40;
    model_pixel(40, 40, ea, es);
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_checks++;
      if (pixel_addr !== ((e >= 2) ? ea : '0)) begin
        n_fail++;
        $display("[TB] FAIL reset_release_addr edge%0d: got %0d expected %0d",
                 e, pixel_addr, (e >= 2) ? ea : '0);
      end
      n_checks++;
      if ({out_show_pixel, out_tile_id, out_is_char_sync, out_spr_idx} !== ((e >= 4) ? es : 7'd0)) begin
        n_fail++;
        $display("[TB] FAIL reset_release_side edge%0d: got %b expected %b", e,
                 {out_show_pixel, out_tile_id, out_is_char_sync, out_spr_idx},
                 (e >= 4) ? es : 7'd0);
      end
    end
    // Mid-frame reset with arbitrary inputs
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      h_cnt       = 10'($urandom_range(0, 700));
      v_cnt       = 10'($urandom_range(0, 500));
      vsync       = 1'($urandom);
      spr_x       = 20'($urandom);
      spr_y       = 20'($urandom);
      spr_en      = 2'($urandom);
      tile_hide   = 16'($urandom);
      tick();
      n_checks++;
      if ({pixel_addr, out_show_pixel, out_tile_id, out_is_char_sync, out_spr_idx} !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs cycle%0d: got addr=%0d side=%b expected all 0", c,
                 pixel_addr, {out_show_pixel, out_tile_id, out_is_char_sync, out_spr_idx});
      end
    end
    vsync     = 1'b0;
    tile_hide = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      ms_x[i] = 0; ms_y[i] = 0; ms_en[i] = 0; ms_flip[i] = 0;
      ms_frame[i] = 0; ms_base[i] = 0; ms_sheet[i] = 0;
    end
    set_sprite(0, 100, 100, 1, 0, 0, 3000, 64);
    set_sprite(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    // Without a vsync edge the sprite at (100,100) stays invisible
    for (int k = 0; k < 6; k++) begin
      ph[k] = 104 + 4 * k;
      pv[k] = 106 + 3 * k;
    end
    run_pixels(6);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (a_addr[k] !== e_addr[k] || a_side[k][1] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL unlatched_sprite px%0d: got addr=%0d side=%b expected addr=%0d side=%b",
                 k, a_addr[k], a_side[k], e_addr[k], e_side[k]);
      end
    end
  endtask

  task automatic test_tile_path();
    write_map(11 * 20 + 3, 8);
    tile_hide = '0;
    ph[0] = 100; pv[0] = 360;
    ph[1] = 127; pv[1] = 383;
    ph[2] = 96;  pv[2] = 352;
    run_pixels(3);
    n_checks++;
    if (a_addr[0] !== 17'd7428) begin
      n_fail++;
      $display("[TB] FAIL tile_addr: got %0d expected 7428", a_addr[0]);
    end
    n_checks++;
    if (a_side[0] !== 7'b1_1000_0_0) begin
      n_fail++;
      $display("[TB] FAIL tile_side: got %b expected 1100000", a_side[0]);
    end
    for (int k = 1; k < 3; k++) begin
      n_checks++;
      if (a_addr[k] !== e_addr[k] || a_side[k] !== e_side[k]) begin
        n_fail++;
        $display("[TB] FAIL tile_px%0d: got addr=%0d side=%b expected addr=%0d side=%b",
                 k, a_addr[k], a_side[k], e_addr[k], e_side[k]);
      end
    end
    tile_hide = 16'h0100;
    run_pixels(1);
    n_checks++;
    if (a_side[0][6] !== 1'b0 || a_addr[0] !== e_addr[0]) begin
      n_fail++;
      $display("[TB] FAIL tile_hidden: got show=%b addr=%0d expected show=0 addr=%0d",
               a_side[0][6], a_addr[0], e_addr[0]);
    end
    tile_hide = '0;
  endtask

  task automatic test_sprite_flip();
    set_sprite(0, 64, 416, 1, 0, 2, 5120, 192);
    set_sprite(1, 0, 0, 0, 0, 0, 0, 0);
    latch_sprites();
    ph[0] = 70; pv[0] = 421;
    ph[1] = 65; pv[1] = 421;
    ph[2] = 92; pv[2] = 447;
    ph[3] = 93; pv[3] = 447;
    ph[4] = 80; pv[4] = 420;
    run_pixels(5);
    n_checks++;
    if (a_addr[0] !== 17'd6150) begin
      n_fail++;
      $display("[TB] FAIL sprite_addr: got %0d expected 6150", a_addr[0]);
    end
    n_checks++;
    if (a_side[1][1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sprite_inset: got is_char=%b expected 0", a_side[1][1]);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (a_addr[k] !== e_addr[k] || a_side[k] !== e_side[k]) begin
        n_fail++;
        $display("[TB] FAIL sprite_px%0d: got addr=%0d side=%b expected addr=%0d side=%b",
                 k, a_addr[k], a_side[k], e_addr[k], e_side[k]);
      end
    end
    set_sprite(0, 64, 416, 1, 1, 2, 5120, 192);
    latch_sprites();
    run_pixels(1);
    n_checks++;
    if (a_addr[0] !== 17'd6169) begin
      n_fail++;
      $display("[TB] FAIL sprite_flip_addr: got %0d expected 6169", a_addr[0]);
    end
  endtask

  task automatic test_priority_latch();
    set_sprite(0, 200, 200, 1, 0, 1, 1000, 64);
    set_sprite(1, 210, 205, 1, 1, 3, 20000, 100);
    latch_sprites();
    ph[0] = 210; pv[0] = 210;
    ph[1] = 235; pv[1] = 230;
    ph[2] = 220; pv[2] = 225;
    run_pixels(3);
    n_checks++;
    if (a_side[0][1:0] !== 2'b10 || a_side[1][1:0] !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL priority: got %b,%b expected 10,11", a_side[0][1:0], a_side[1][1:0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (a_addr[k] !== e_addr[k] || a_side[k] !== e_side[k]) begin
        n_fail++;
        $display("[TB] FAIL priority_px%0d: got addr=%0d side=%b expected addr=%0d side=%b",
                 k, a_addr[k], a_side[k], e_addr[k], e_side[k]);
      end
    end
    // A mid-frame move must not take effect yet
    spr_x[9:0] = 10'd400;
    run_pixels(3);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (a_addr[k] !== e_addr[k] || a_side[k] !== e_side[k]) begin
        n_fail++;
        $display("[TB] FAIL midframe_px%0d: got addr=%0d side=%b expected addr=%0d side=%b",
                 k, a_addr[k], a_side[k], e_addr[k], e_side[k]);
      end
    end
    // vsync held high for 10 cycles latches only the value present at its rising edge
    spr_x[9:0] = 10'd300;
    h_cnt = 10'd800;
    v_cnt = 10'd600;
    vsync = 1'b1;
    tick();
    model_capture();
    spr_x[9:0] = 10'd500;
    repeat (9) tick();
    vsync = 1'b0;
    tick();
    ph[0] = 310; pv[0] = 210;
    ph[1] = 510; pv[1] = 210;
    run_pixels(2);
    n_checks++;
    if (a_side[0][1] !== 1'b1 || a_side[1][1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_latch: got is_char %b,%b expected 1,0", a_side[0][1], a_side[1][1]);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (a_addr[k] !== e_addr[k] || a_side[k] !== e_side[k]) begin
        n_fail++;
        $display("[TB] FAIL latch_px%0d: got addr=%0d side=%b expected addr=%0d side=%b",
                 k, a_addr[k], a_side[k], e_addr[k], e_side[k]);
      end
    end
  endtask

  task automatic test_boundaries();
    spr_en = '0;
    latch_sprites();
    tile_hide = '0;
    write_map(0, 2);
    write_map(20, 4);
    write_map(299, 7);
    write_map(43, 6);
    write_map(300, 9);
    write_map(511, 9);
    ph[0] = 0;   pv[0] = 0;
    ph[1] = 0;   pv[1] = 32;
    ph[2] = 639; pv[2] = 479;
    ph[3] = 640; pv[3] = 0;
    ph[4] = 0;   pv[4] = 480;
    ph[5] = 96;  pv[5] = 64;
    ph[6] = 97;  pv[6] = 65;
    pw_en[5] = 1'b1; pw_addr[5] = 43; pw_data[5] = 11;
    run_pixels(7);
    n_checks++;
    if (a_side[2][6] !== 1'b1 || a_side[2][5:2] !== 4'd7) begin
      n_fail++;
      $display("[TB] FAIL corner_in_screen: got show=%b tid=%0d expected show=1 tid=7",
               a_side[2][6], a_side[2][5:2]);
    end
    n_checks++;
    if (a_side[3][6:2] !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL off_screen: got show=%b tid=%0d expected show=0 tid=0",
               a_side[3][6], a_side[3][5:2]);
    end
    n_checks++;
    if (a_side[5][5:2] !== 4'd6 || a_side[6][5:2] !== 4'd11) begin
      n_fail++;
      $display("[TB] FAIL read_first: got tid %0d,%0d expected 6,11", a_side[5][5:2], a_side[6][5:2]);
    end
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (a_addr[k] !== e_addr[k] || a_side[k] !== e_side[k]) begin
        n_fail++;
        $display("[TB] FAIL boundary_px%0d: got addr=%0d side=%b expected addr=%0d side=%b",
                 k, a_addr[k], a_side[k], e_addr[k], e_side[k]);
      end
    end
  endtask

  task automatic test_random();
    int i;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < NUM_SPR; s++)
        set_sprite(s, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 131071),
                   $urandom_range(0, 255));
      tile_hide = 16'($urandom) & 16'($urandom);
      latch_sprites();
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          i = $urandom_range(0, NUM_SPR - 1);
          ph[k] = ms_x[i] + $urandom_range(0, 31);
          pv[k] = ms_y[i] + $urandom_range(0, 31);
          if (ph[k] > 1023) ph[k] = 1023;
          if (pv[k] > 1023) pv[k] = 1023;
        end else begin
          ph[k] = $urandom_range(0, 700);
          pv[k] = $urandom_range(0, 520);
        end
        pw_en[k]   = ($urandom_range(0, 3) == 0);
        pw_addr[k] = $urandom_range(0, 319);
        pw_data[k] = $urandom_range(0, 15);
      end
      run_pixels(40);
      for (int k = 0; k < 40; k++) begin
        n_checks++;
        if (a_addr[k] !== e_addr[k] || a_side[k] !== e_side[k]) begin
          n_fail++;
          $display("[TB] FAIL random_r%0d_px%0d (%0d,%0d): got addr=%0d side=%b expected addr=%0d side=%b",
                   r, k, ph[k], pv[k], a_addr[k], a_side[k], e_addr[k], e_side[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < MAXPIX; k++) begin
      pw_en[k] = 1'b0; pw_addr[k] = 0; pw_data[k] = 0;
    end
    for (int i = 0; i < NUM_SPR; i++) begin
      ms_x[i] = 0; ms_y[i] = 0; ms_en[i] = 0; ms_flip[i] = 0;
      ms_frame[i] = 0; ms_base[i] = 0; ms_sheet[i] = 0;
    end
    rst = 1'b0;
    tick();
    tick();
    for (int a = 0; a < MAP_N; a++) write_map(a, $urandom_range(0, 15));
    write_map(21, 5);
    test_reset();
    test_tile_path();
    test_sprite_flip();
    test_priority_latch();
    test_boundaries();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
